// File: rtl/nodf_module_status_tracker.sv
`default_nettype none
// ============================================================================
// Module   : nodf_module_status_tracker
// Function : Passive monitor for an ap_ctrl_hs handshake. It tracks per-cycle
//            state, handshake counts and transaction latency, and freezes its
//            statistics when finish is seen.
// Revision : 1.0
// ============================================================================
module nodf_module_status_tracker #(
  parameter int CNT_W = 32,
  parameter int LAT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ap_start,
  input  logic             ap_ready,
  input  logic             ap_done,
  input  logic             ap_continue,
  input  logic             finish,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] start_cnt,
  output logic [CNT_W-1:0] ready_cnt,
  output logic [CNT_W-1:0] done_cnt,
  output logic [CNT_W-1:0] idle_cycles,
  output logic [CNT_W-1:0] busy_cycles,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [LAT_W-1:0] last_lat,
  output logic [LAT_W-1:0] min_lat,
  output logic [LAT_W-1:0] max_lat,
  output logic             frozen
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_WAIT = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [LAT_W-1:0] C_LAT_MAX = {LAT_W{1'b1}};
  localparam logic [LAT_W-1:0] C_LAT_ONE = {{(LAT_W-1){1'b0}}, 1'b1};

  state_t           r_state, w_state_nxt;
  logic [LAT_W-1:0] r_lat, w_lat_nxt, w_lat_inc;
  logic [LAT_W-1:0] r_cap_lat, w_cap_nxt;
  logic [LAT_W-1:0] w_done_lat;
  logic             w_complete;

  logic [CNT_W-1:0] r_start_cnt, r_ready_cnt, r_done_cnt;
  logic [CNT_W-1:0] r_idle_cycles, r_busy_cycles, r_stall_cycles;
  logic [LAT_W-1:0] r_last_lat, r_min_lat, r_max_lat;
  logic             r_frozen;

  function automatic logic [CNT_W-1:0] sat_cnt(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != C_CNT_MAX)) ? v + C_CNT_ONE : v;
  endfunction

  always_comb begin
    w_state_nxt = r_state;
    w_lat_nxt   = r_lat;
    w_cap_nxt   = r_cap_lat;
    w_complete  = 1'b0;
    w_done_lat  = '0;
    w_lat_inc   = (r_lat == C_LAT_MAX) ? r_lat : r_lat + C_LAT_ONE;
    case (r_state)
      S_IDLE: begin
        if (ap_start) begin
          if (ap_done && ap_continue) begin
            // zero-latency transaction completes without leaving IDLE
            w_complete = 1'b1;
          end else if (ap_done) begin
            w_state_nxt = S_WAIT;
            w_cap_nxt   = '0;
          end else begin
            w_state_nxt = S_BUSY;
            w_lat_nxt   = '0;
          end
        end
      end
      S_BUSY: begin
        // w_lat_inc equals (current cycle index - start cycle index)
        w_lat_nxt = w_lat_inc;
        if (ap_done) begin
          if (ap_continue) begin
            w_complete = 1'b1;
            w_done_lat = w_lat_inc;
            if (ap_start) begin
              w_lat_nxt = '0;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end else begin
            w_state_nxt = S_WAIT;
            w_cap_nxt   = w_lat_inc;
          end
        end
      end
      S_WAIT: begin
        if (ap_continue) begin
          w_complete = 1'b1;
          w_done_lat = r_cap_lat;
          if (ap_start) begin
            w_state_nxt = S_BUSY;
            w_lat_nxt   = '0;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state        <= S_IDLE;
      r_lat          <= '0;
      r_cap_lat      <= '0;
      r_start_cnt    <= '0;
      r_ready_cnt    <= '0;
      r_done_cnt     <= '0;
      r_idle_cycles  <= '0;
      r_busy_cycles  <= '0;
      r_stall_cycles <= '0;
      r_last_lat     <= '0;
      r_min_lat      <= C_LAT_MAX;
      r_max_lat      <= '0;
      r_frozen       <= 1'b0;
    end else if (!r_frozen) begin
      r_state        <= w_state_nxt;
      r_lat          <= w_lat_nxt;
      r_cap_lat      <= w_cap_nxt;
      r_start_cnt    <= sat_cnt(r_start_cnt, ap_start & ap_ready);
      r_ready_cnt    <= sat_cnt(r_ready_cnt, ap_ready);
      r_done_cnt     <= sat_cnt(r_done_cnt, w_complete);
      r_idle_cycles  <= sat_cnt(r_idle_cycles, r_state == S_IDLE);
      r_busy_cycles  <= sat_cnt(r_busy_cycles, r_state == S_BUSY);
      r_stall_cycles <= sat_cnt(r_stall_cycles, r_state == S_WAIT);
      if (w_complete) begin
        r_last_lat <= w_done_lat;
        if (w_done_lat < r_min_lat) r_min_lat <= w_done_lat;
        if (w_done_lat > r_max_lat) r_max_lat <= w_done_lat;
      end
      if (finish) r_frozen <= 1'b1;
    end
  end

  assign state        = r_state;
  assign start_cnt    = r_start_cnt;
  assign ready_cnt    = r_ready_cnt;
  assign done_cnt     = r_done_cnt;
  assign idle_cycles  = r_idle_cycles;
  assign busy_cycles  = r_busy_cycles;
  assign stall_cycles = r_stall_cycles;
  assign last_lat     = r_last_lat;
  assign min_lat      = r_min_lat;
  assign max_lat      = r_max_lat;
  assign frozen       = r_frozen;

endmodule
`default_nettype wire

// File: tb/tb_nodf_module_status_tracker.sv
`default_nettype none
// ============================================================================
// Module   : tb_nodf_module_status_tracker
// Function : Directed self-checking bench for nodf_module_status_tracker.
// Revision : 1.0
// ============================================================================
module tb_nodf_module_status_tracker;

  logic        clock, reset;
  logic        ap_start, ap_ready, ap_done, ap_continue, finish;
  logic [1:0]  state;
  logic [31:0] start_cnt, ready_cnt, done_cnt;
  logic [31:0] idle_cycles, busy_cycles, stall_cycles;
  logic [31:0] last_lat, min_lat, max_lat;
  logic        frozen;
  int          n_cmp = 0;
  int          n_bad = 0;

  nodf_module_status_tracker #(.CNT_W(32), .LAT_W(32)) dut (
    .clock(clock), .reset(reset),
    .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done),
    .ap_continue(ap_continue), .finish(finish),
    .state(state), .start_cnt(start_cnt), .ready_cnt(ready_cnt),
    .done_cnt(done_cnt), .idle_cycles(idle_cycles), .busy_cycles(busy_cycles),
    .stall_cycles(stall_cycles), .last_lat(last_lat), .min_lat(min_lat),
    .max_lat(max_lat), .frozen(frozen)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // inputs change at negedge, DUT samples at posedge, checks at next negedge
  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic clr_inputs();
    ap_start = 1'b0; ap_ready = 1'b0; ap_done = 1'b0;
    ap_continue = 1'b1; finish = 1'b0;
  endtask

  task automatic do_reset();
    clr_inputs();
    reset = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    clr_inputs();
    reset = 1'b0;
    repeat (3) @(negedge clock);
    n_cmp++; if (state !== 2'b00) begin n_bad++; $display("FAIL rst_state: got %b want 00", state); end
    n_cmp++; if (min_lat !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL rst_min_lat: got %h want ffffffff", min_lat); end
    n_cmp++; if (frozen !== 1'b0) begin n_bad++; $display("FAIL rst_frozen: got %b want 0", frozen); end
    reset = 1'b1;
    repeat (10) tick();
    n_cmp++; if (state !== 2'b00) begin n_bad++; $display("FAIL idle_state: got %b want 00", state); end
    n_cmp++; if (idle_cycles !== 32'd10) begin n_bad++; $display("FAIL idle_cycles: got %0d want 10", idle_cycles); end
    n_cmp++; if (busy_cycles !== 32'd0 || stall_cycles !== 32'd0) begin n_bad++; $display("FAIL idle_other_cycles: got %0d/%0d want 0/0", busy_cycles, stall_cycles); end
    n_cmp++; if (start_cnt !== 32'd0 || ready_cnt !== 32'd0 || done_cnt !== 32'd0) begin n_bad++; $display("FAIL idle_counts: got %0d/%0d/%0d want 0/0/0", start_cnt, ready_cnt, done_cnt); end
    n_cmp++; if (last_lat !== 32'd0 || max_lat !== 32'd0 || min_lat !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL idle_lat: got %0d/%0d/%h want 0/0/ffffffff", last_lat, max_lat, min_lat); end
  endtask

  task automatic test_single();
    do_reset();
    ap_start = 1'b1; ap_ready = 1'b1;
    tick();
    ap_start = 1'b0; ap_ready = 1'b0;
    repeat (4) tick();
    n_cmp++; if (state !== 2'b01) begin n_bad++; $display("FAIL single_busy_state: got %b want 01", state); end
    ap_done = 1'b1;
    tick();
    ap_done = 1'b0;
    n_cmp++; if (state !== 2'b00) begin n_bad++; $display("FAIL single_end_state: got %b want 00", state); end
    n_cmp++; if (start_cnt !== 32'd1 || ready_cnt !== 32'd1) begin n_bad++; $display("FAIL single_start_ready: got %0d/%0d want 1/1", start_cnt, ready_cnt); end
    n_cmp++; if (done_cnt !== 32'd1) begin n_bad++; $display("FAIL single_done_cnt: got %0d want 1", done_cnt); end
    n_cmp++; if (last_lat !== 32'd5 || min_lat !== 32'd5 || max_lat !== 32'd5) begin n_bad++; $display("FAIL single_lat: got %0d/%0d/%0d want 5/5/5", last_lat, min_lat, max_lat); end
    n_cmp++; if (busy_cycles !== 32'd5 || idle_cycles !== 32'd1 || stall_cycles !== 32'd0) begin n_bad++; $display("FAIL single_cycles: got %0d/%0d/%0d want 5/1/0", busy_cycles, idle_cycles, stall_cycles); end
  endtask

  task automatic test_zero_latency();
    do_reset();
    ap_start = 1'b1; ap_ready = 1'b1; ap_done = 1'b1;
    tick();
    clr_inputs();
    n_cmp++; if (state !== 2'b00) begin n_bad++; $display("FAIL zero_state: got %b want 00", state); end
    n_cmp++; if (done_cnt !== 32'd1 || last_lat !== 32'd0 || min_lat !== 32'd0) begin n_bad++; $display("FAIL zero_lat: got %0d/%0d/%0d want 1/0/0", done_cnt, last_lat, min_lat); end
    n_cmp++; if (busy_cycles !== 32'd0 || idle_cycles !== 32'd1) begin n_bad++; $display("FAIL zero_cycles: got %0d/%0d want 0/1", busy_cycles, idle_cycles); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    ap_start = 1'b1; ap_ready = 1'b1;
    tick();
    ap_start = 1'b0; ap_ready = 1'b0;
    repeat (3) tick();
    ap_done = 1'b1; ap_start = 1'b1; ap_ready = 1'b1;
    tick();
    clr_inputs();
    n_cmp++; if (state !== 2'b01) begin n_bad++; $display("FAIL b2b_mid_state: got %b want 01", state); end
    n_cmp++; if (done_cnt !== 32'd1 || last_lat !== 32'd4) begin n_bad++; $display("FAIL b2b_first: got %0d/%0d want 1/4", done_cnt, last_lat); end
    repeat (6) tick();
    ap_done = 1'b1;
    tick();
    clr_inputs();
    n_cmp++; if (state !== 2'b00) begin n_bad++; $display("FAIL b2b_end_state: got %b want 00", state); end
    n_cmp++; if (done_cnt !== 32'd2 || start_cnt !== 32'd2) begin n_bad++; $display("FAIL b2b_counts: got %0d/%0d want 2/2", done_cnt, start_cnt); end
    n_cmp++; if (min_lat !== 32'd4 || max_lat !== 32'd7 || last_lat !== 32'd7) begin n_bad++; $display("FAIL b2b_lat: got %0d/%0d/%0d want 4/7/7", min_lat, max_lat, last_lat); end
    n_cmp++; if (busy_cycles !== 32'd11) begin n_bad++; $display("FAIL b2b_busy: got %0d want 11", busy_cycles); end
  endtask

  task automatic test_stall();
    do_reset();
    ap_start = 1'b1; ap_ready = 1'b1;
    tick();
    ap_start = 1'b0; ap_ready = 1'b0;
    tick();
    ap_done = 1'b1; ap_continue = 1'b0;
    tick();
    n_cmp++; if (state !== 2'b10) begin n_bad++; $display("FAIL stall_enter_state: got %b want 10", state); end
    repeat (2) tick();
    n_cmp++; if (state !== 2'b10 || done_cnt !== 32'd0) begin n_bad++; $display("FAIL stall_hold: got %b/%0d want 10/0", state, done_cnt); end
    ap_continue = 1'b1;
    tick();
    clr_inputs();
    n_cmp++; if (state !== 2'b00 || done_cnt !== 32'd1) begin n_bad++; $display("FAIL stall_release: got %b/%0d want 00/1", state, done_cnt); end
    n_cmp++; if (stall_cycles !== 32'd3 || busy_cycles !== 32'd2) begin n_bad++; $display("FAIL stall_cycles: got %0d/%0d want 3/2", stall_cycles, busy_cycles); end
    n_cmp++; if (last_lat !== 32'd2) begin n_bad++; $display("FAIL stall_lat: got %0d want 2", last_lat); end
  endtask

  task automatic test_ready_only();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      ap_ready = 1'b1;
      tick();
      ap_ready = 1'b0;
      tick();
    end
    n_cmp++; if (ready_cnt !== 32'd4 || start_cnt !== 32'd0) begin n_bad++; $display("FAIL ronly_counts: got %0d/%0d want 4/0", ready_cnt, start_cnt); end
    n_cmp++; if (state !== 2'b00 || idle_cycles !== 32'd8) begin n_bad++; $display("FAIL ronly_state: got %b/%0d want 00/8", state, idle_cycles); end
  endtask

  task automatic test_freeze_reset();
    do_reset();
    ap_start = 1'b1; ap_ready = 1'b1;
    tick();
    ap_start = 1'b0; ap_ready = 1'b0;
    repeat (2) tick();
    finish = 1'b1; ap_ready = 1'b1;
    tick();
    n_cmp++; if (frozen !== 1'b1) begin n_bad++; $display("FAIL frz_flag: got %b want 1", frozen); end
    n_cmp++; if (ready_cnt !== 32'd2 || busy_cycles !== 32'd3 || state !== 2'b01) begin n_bad++; $display("FAIL frz_capture: got %0d/%0d/%b want 2/3/01", ready_cnt, busy_cycles, state); end
    finish = 1'b0;
    for (int i = 0; i < 6; i++) begin
      ap_start = i[0]; ap_ready = ~i[0]; ap_done = 1'b1; ap_continue = i[1];
      tick();
    end
    n_cmp++; if (ready_cnt !== 32'd2 || start_cnt !== 32'd1 || done_cnt !== 32'd0) begin n_bad++; $display("FAIL frz_hold_counts: got %0d/%0d/%0d want 2/1/0", ready_cnt, start_cnt, done_cnt); end
    n_cmp++; if (busy_cycles !== 32'd3 || idle_cycles !== 32'd1 || state !== 2'b01 || last_lat !== 32'd0) begin n_bad++; $display("FAIL frz_hold_state: got %0d/%0d/%b/%0d want 3/1/01/0", busy_cycles, idle_cycles, state, last_lat); end
    #2 reset = 1'b0;
    #1;
    n_cmp++; if (frozen !== 1'b0 || state !== 2'b00) begin n_bad++; $display("FAIL async_rst_state: got %b/%b want 0/00", frozen, state); end
    n_cmp++; if (ready_cnt !== 32'd0 || busy_cycles !== 32'd0 || min_lat !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL async_rst_vals: got %0d/%0d/%h want 0/0/ffffffff", ready_cnt, busy_cycles, min_lat); end
    @(negedge clock);
    clr_inputs();
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    clr_inputs();
    test_reset();
    test_single();
    test_zero_latency();
    test_back_to_back();
    test_stall();
    test_ready_only();
    test_freeze_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/nodf_module_status_tracker.md
# nodf_module_status_tracker

Cycle-accurate status tracker for one non-dataflow HLS module's block-level handshake (ap_start/ap_ready/ap_done/ap_continue). It sits in the simulation/debug fabric beside each monitored module instance and observes it passively. It classifies every clock cycle as idle, busy or stalled, and counts handshakes. It also measures per-transaction latency, and freezes all statistics when the run-level `finish` is seen so they can be dumped.

## Interface
- CNT_W, 32: width of all event/cycle counters (saturating).
- LAT_W, 32: width of latency registers.
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- ap_start  in  1  monitored module start request (tie 0 if unavailable).
- ap_ready  in  1  monitored module input-accepted strobe.
- ap_done  in  1  monitored module completion strobe.
- ap_continue  in  1  downstream accept of done (tie 1 if module has none).
- finish  in  1  end-of-simulation indication.
- state  out  2  00 IDLE, 01 BUSY, 10 WAIT_CONT; 11 unused.
- start_cnt  out  CNT_W  cycles with ap_start & ap_ready.
- ready_cnt  out  CNT_W  cycles with ap_ready.
- done_cnt  out  CNT_W  cycles with ap_done & ap_continue.
- idle_cycles / busy_cycles / stall_cycles  out  CNT_W each  cycles spent in each state.
- last_lat, min_lat, max_lat  out  LAT_W each  transaction latency statistics.
- frozen  out  1  high once finish has been captured.

## Operation
- All inputs sampled at rising clock; monitor never drives the observed module.
- State machine, evaluated on sampled inputs when frozen=0:
  - IDLE: ap_start=1 → BUSY, latency counter cleared to 0. Exception: ap_start & ap_done & ap_continue in the same cycle completes with latency 0 and stays IDLE. ap_start & ap_done & !ap_continue → WAIT_CONT with latency 0.
  - BUSY: latency counter increments each cycle. On ap_done & ap_continue the transaction completes. Next state is BUSY if ap_start=1 (back-to-back, latency counter cleared), else IDLE. On ap_done & !ap_continue → WAIT_CONT; latency is captured at this cycle.
  - WAIT_CONT: held until ap_continue=1 (ap_done is ignored). On release, done_cnt increments and the completion is recorded. Next state is BUSY if ap_start=1, else IDLE.
- Completion recording: last_lat is the number of cycles from the start-sampled cycle to the done-sampled cycle (done cycle index minus start cycle index). min_lat and max_lat are updated from last_lat. done_cnt increments once per completion.
- Cycle counters: exactly one of idle_cycles, busy_cycles or stall_cycles increments per unfrozen cycle, selected by the current (pre-transition) state.
- start_cnt and ready_cnt are independent of state. ready_cnt also counts ready pulses on modules whose ap_start is tied 0.
- Counters saturate at all-ones and never wrap. The latency counter also saturates.
- finish sampled 1 sets frozen on that edge. That cycle's own events are still counted. After that, all outputs hold until reset, whatever the inputs do.

## Timing
- All outputs are registered. An event sampled at edge N is visible after edge N.
- Reset values: state=IDLE, every counter=0, last_lat=0, max_lat=0, min_lat=all-ones (means no transaction yet), frozen=0.
- Reset asserted mid-transaction clears everything immediately (asynchronously). Operation resumes on the first rising edge after reset deasserts.
- Simultaneous ap_done & ap_start in BUSY: the completion and the new start are both handled in one cycle.

## Test plan
- Reset then idle: hold reset=0 for 3 cycles, release, 10 idle cycles → state=00, idle_cycles=10, all others 0, min_lat=0xFFFFFFFF.
- Single transaction: ap_start=1 at cycle 0 (ready same cycle), ap_done=1 at cycle 5, ap_continue=1 → start_cnt=1, done_cnt=1, last_lat=5, min_lat=max_lat=5, busy_cycles=5.
- Back-to-back: done and new start in the same cycle, latencies 4 then 7 → state stays BUSY across the boundary, done_cnt=2, min_lat=4, max_lat=7, last_lat=7.
- Continue stall: ap_done=1 with ap_continue=0 for 3 cycles, then 1 → state=10 for 3 cycles, stall_cycles=3, done_cnt increments only on release.
- Ready-only module: ap_start=ap_done=0, four 1-cycle ap_ready pulses → ready_cnt=4, start_cnt=0, state stays IDLE.
- Finish freeze and mid-run reset: pulse finish, then keep toggling handshakes → frozen=1 and no counter changes. Then assert reset asynchronously mid-clock → all outputs return to their reset values before the next edge.
